spm_stream_feeder: RTL and testbench

- Transmit side of the arbiter-to-channel sparse-matrix stream. Per channel, it fetches three CISR arrays from a shared word-addressed read port: nonzero values, column indices and row lengths.
- It buffers each array in its own small FIFO and drives one beat per cycle into a channel over spm_val, spm_col_idx, spm_row_len, spm_fetch_stall and spm_fetch_done.
- One instance sits between the memory arbiter and each channel.

---
 rtl/spm_feed_pkg.sv | 19 +
 rtl/spm_stream_fifo.sv | 45 ++++
 rtl/spm_stream_feeder.sv | 208 ++++++++++++++++++++
 tb/tb_spm_stream_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_feed_pkg.sv
// Shared tags, FSM state type and round-robin helper for the sparse-matrix stream feeder.
package spm_feed_pkg;

  localparam logic [1:0] TAG_VAL = 2'd0;
  localparam logic [1:0] TAG_COL = 2'd1;
  localparam logic [1:0] TAG_LEN = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feed_state_e;

  // Stream that follows t in round-robin order (VAL -> COL -> LEN -> VAL).
  function automatic logic [1:0] rr_next(input logic [1:0] t);
    return (t == TAG_LEN) ? TAG_VAL : t + 2'd1;
  endfunction

endpackage

// File: rtl/spm_stream_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous clear.
module spm_stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int COUNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  pop_data,
  output logic [COUNT_W-1:0] count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + COUNT_W'(1);
      else if (!push && pop) count <= count - COUNT_W'(1);
    end
  end

endmodule

// File: rtl/spm_stream_feeder.sv
// Fetches value/column/row-length arrays over a shared read port and emits one beat per cycle.
//   state | meaning
//   IDLE  | no job; waiting for start
//   RUN   | issuing reads and emitting beats
//   DONE  | all beats emitted; done held until start/reset/init
module spm_stream_feeder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spmv_init,
  input  logic              start,
  input  logic [ADDR_W-1:0] val_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] len_base,
  input  logic [CNT_W-1:0]  nnz_count,
  input  logic [CNT_W-1:0]  row_count,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [1:0]        mem_req_tag,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [1:0]        mem_rsp_tag,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [DATA_W-1:0] spm_val,
  output logic [DATA_W-1:0] spm_col_idx,
  output logic [DATA_W-1:0] spm_row_len,
  output logic              spm_fetch_stall,
  output logic              spm_fetch_done,
  output logic              busy
);
  import spm_feed_pkg::*;

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SQ_W  = OCC_W + 1;
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(FIFO_DEPTH);

  feed_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q  [3];
  logic [CNT_W-1:0]  issued  [3];
  logic [OCC_W-1:0]  outst   [3];
  logic [SQ_W-1:0]   squash  [3];
  logic [OCC_W-1:0]  occ     [3];
  logic [DATA_W-1:0] fifo_dout [3];
  logic [CNT_W-1:0]  nnz_q, row_q, beats_q, beat_k, start_beats;

  logic [2:0] elig, issue_hit, rsp_hit, rsp_sq, rsp_take, pop;
  logic [1:0] last_q, lock_tag_q, c0, c1, c2, pick, req_tag;
  logic       lock_q, accept, need_vc, need_len, beat_ok;
  logic       fire, job_start;

  assign busy        = (state_q == RUN);
  assign start_beats = (nnz_count > row_count) ? nnz_count : row_count;

  always_comb begin
    elig = '0;
    for (int s = 0; s < 3; s++) begin
      elig[s] = (state_q == RUN)
             && (issued[s] < ((2'(s) == TAG_LEN) ? row_q : nnz_q))
             && (({1'b0, occ[s]} + {1'b0, outst[s]}) < DEPTH_C);
    end
    c0   = rr_next(last_q);
    c1   = rr_next(c0);
    c2   = rr_next(c1);
    pick = elig[c0] ? c0 : (elig[c1] ? c1 : c2);
    // Once offered, a request keeps its tag until accepted.
    req_tag       = lock_q ? lock_tag_q : pick;
    mem_req_tag   = req_tag;
    mem_req_valid = !spmv_init && (state_q == RUN) && (lock_q || (|elig));
    mem_req_addr  = base_q[req_tag] + ADDR_W'(issued[req_tag]);
    accept        = mem_req_valid && mem_req_ready;

    issue_hit = '0;
    rsp_hit   = '0;
    rsp_sq    = '0;
    rsp_take  = '0;
    for (int s = 0; s < 3; s++) begin
      issue_hit[s] = accept && (req_tag == 2'(s));
      rsp_hit[s]   = mem_rsp_valid && (mem_rsp_tag == 2'(s));
      rsp_sq[s]    = rsp_hit[s] && (squash[s] != '0);
      rsp_take[s]  = rsp_hit[s] && (squash[s] == '0) && (outst[s] != '0);
    end

    need_vc  = beat_k < nnz_q;
    need_len = beat_k < row_q;
    beat_ok  = (!need_vc || ((occ[0] != '0) && (occ[1] != '0)))
            && (!need_len || (occ[2] != '0));
    pop[0]   = fire && need_vc;
    pop[1]   = fire && need_vc;
    pop[2]   = fire && need_len;
  end

  always_comb begin
    state_d   = state_q;
    fire      = 1'b0;
    job_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          job_start = 1'b1;
          state_d   = (start_beats == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (beat_k == beats_q) state_d = DONE;
        else if (beat_ok)      fire    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (spmv_init) begin
      state_d   = IDLE;
      fire      = 1'b0;
      job_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  for (genvar s = 0; s < 3; s++) begin : g_fifo
    spm_stream_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (spmv_init),
      .push      (rsp_take[s]),
      .push_data (mem_rsp_data),
      .pop       (pop[s]),
      .pop_data  (fifo_dout[s]),
      .count     (occ[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        base_q[s] <= '0;
        issued[s] <= '0;
        outst[s]  <= '0;
        squash[s] <= '0;
      end
      nnz_q           <= '0;
      row_q           <= '0;
      beats_q         <= '0;
      beat_k          <= '0;
      last_q          <= TAG_LEN;
      lock_q          <= 1'b0;
      lock_tag_q      <= TAG_VAL;
      spm_val         <= '0;
      spm_col_idx     <= '0;
      spm_row_len     <= '0;
      spm_fetch_stall <= 1'b1;
      spm_fetch_done  <= 1'b0;
    end else if (spmv_init) begin
      // Everything still in flight becomes stale and must be absorbed on arrival.
      for (int s = 0; s < 3; s++) begin
        squash[s] <= squash[s] - SQ_W'(rsp_sq[s]) + SQ_W'(outst[s]) - SQ_W'(rsp_take[s]);
        issued[s] <= '0;
        outst[s]  <= '0;
      end
      beat_k          <= '0;
      lock_q          <= 1'b0;
      spm_val         <= '0;
      spm_col_idx     <= '0;
      spm_row_len     <= '0;
      spm_fetch_stall <= 1'b1;
      spm_fetch_done  <= 1'b0;
    end else begin
      if (job_start) begin
        base_q[0] <= val_base;
        base_q[1] <= col_base;
        base_q[2] <= len_base;
        for (int s = 0; s < 3; s++) issued[s] <= '0;
        nnz_q   <= nnz_count;
        row_q   <= row_count;
        beats_q <= start_beats;
        beat_k  <= '0;
      end
      if (accept) begin
        issued[req_tag] <= issued[req_tag] + CNT_W'(1);
        last_q          <= req_tag;
        lock_q          <= 1'b0;
      end else if (mem_req_valid) begin
        lock_q     <= 1'b1;
        lock_tag_q <= req_tag;
      end
      for (int s = 0; s < 3; s++) begin
        if (issue_hit[s] && !rsp_take[s])      outst[s] <= outst[s] + OCC_W'(1);
        else if (!issue_hit[s] && rsp_take[s]) outst[s] <= outst[s] - OCC_W'(1);
        if (rsp_sq[s]) squash[s] <= squash[s] - SQ_W'(1);
      end
      if (fire) begin
        beat_k      <= beat_k + CNT_W'(1);
        spm_val     <= need_vc  ? fifo_dout[0] : '0;
        spm_col_idx <= need_vc  ? fifo_dout[1] : '0;
        spm_row_len <= need_len ? fifo_dout[2] : '0;
      end
      spm_fetch_stall <= !fire;
      spm_fetch_done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_spm_stream_feeder.sv
// Randomized bench for spm_stream_feeder: behavioural memory, expected beat list built from array contents.
module tb_spm_stream_feeder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spmv_init = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] val_base = '0, col_base = '0, len_base = '0;
  logic [CW-1:0] nnz_count = '0, row_count = '0;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic [1:0]    mem_req_tag;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [1:0]    mem_rsp_tag = '0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic [DW-1:0] spm_val, spm_col_idx, spm_row_len;
  logic          spm_fetch_stall, spm_fetch_done, busy;

  spm_stream_feeder #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .start(start),
    .val_base(val_base), .col_base(col_base), .len_base(len_base),
    .nnz_count(nnz_count), .row_count(row_count),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_data(mem_rsp_data), .spm_val(spm_val), .spm_col_idx(spm_col_idx),
    .spm_row_len(spm_row_len), .spm_fetch_stall(spm_fetch_stall),
    .spm_fetch_done(spm_fetch_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] tag; logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] v; logic [31:0] c; logic [31:0] l; } beat_t;

  int    checks = 0, failures = 0;
  int    cyc = 0;
  req_t  pend[$];
  beat_t obs[$];
  int    lat[3] = '{2, 2, 2};
  int    lat_jit = 0, ready_mode = 0, low_from = 0, low_to = 0;
  int    acc_limit = 1 << 30;
  bit    inj_tag3 = 1'b0;
  int    acc[3], popped[3];
  int    acc_total = 0, hold_viol = 0, max_inflight = 0;
  int    job_nnz = 0, job_rows = 0, done_cyc = 0, last_beat_cyc = 0;
  bit    done_seen = 1'b0;
  bit    prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [1:0]  prev_tag;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Memory model and observer; samples mid-cycle, then drives the next cycle's memory inputs.
  always @(negedge clk) begin
    bit    found;
    int    sel;
    bit    seen[3];
    logic  r;
    beat_t b;
    cyc++;
    if (rst_n && !spm_fetch_stall) begin
      b.v = spm_val; b.c = spm_col_idx; b.l = spm_row_len;
      if (obs.size() < job_nnz) begin popped[0]++; popped[1]++; end
      if (obs.size() < job_rows) popped[2]++;
      obs.push_back(b);
      last_beat_cyc = cyc;
    end
    if (rst_n && spm_fetch_done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (prev_hold && rst_n && !spmv_init &&
        (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr || mem_req_tag !== prev_tag))
      hold_viol++;
    for (int s = 0; s < 3; s++)
      if (acc[s] - popped[s] > max_inflight) max_inflight = acc[s] - popped[s];

    case (ready_mode)
      1:       r = !(cyc >= low_from && cyc < low_to);
      2:       r = ($urandom_range(0, 2) != 0);
      default: r = 1'b1;
    endcase
    if (acc_total >= acc_limit) r = 1'b0;
    mem_req_ready = r;

    mem_rsp_valid = 1'b0;
    found = 1'b0;
    sel = 0;
    seen = '{1'b0, 1'b0, 1'b0};
    foreach (pend[i]) begin
      if (!found) begin
        if (!seen[pend[i].tag] && pend[i].due <= cyc) begin found = 1'b1; sel = i; end
        seen[pend[i].tag] = 1'b1;
      end
    end
    if (found) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = pend[sel].tag;
      mem_rsp_data  = mw(pend[sel].addr);
      pend.delete(sel);
    end else if (inj_tag3 && $urandom_range(0, 3) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 2'd3;
      mem_rsp_data  = $urandom;
    end

    if (rst_n && mem_req_valid && mem_req_ready) begin
      pend.push_back('{mem_req_tag, mem_req_addr,
                       cyc + lat[mem_req_tag] + $urandom_range(0, lat_jit)});
      acc[mem_req_tag]++;
      acc_total++;
    end
    prev_hold = rst_n && mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    prev_tag  = mem_req_tag;
  end

  task automatic pulse_start(input int nnz, input int rows,
                             input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] lb);
    @(posedge clk); #1;
    val_base = vb; col_base = cb; len_base = lb;
    nnz_count = CW'(nnz); row_count = CW'(rows);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obs.delete();
    acc = '{0, 0, 0}; popped = '{0, 0, 0};
    acc_total = 0; max_inflight = 0; hold_viol = 0;
    done_seen = 1'b0; job_nnz = nnz; job_rows = rows;
  endtask

  task automatic run_job(input string name, input int nnz, input int rows,
                         input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] lb);
    int nb, budget;
    logic [31:0] ev, ec, el;
    nb = (nnz > rows) ? nnz : rows;
    pulse_start(nnz, rows, vb, cb, lb);
    budget = 0;
    while (!done_seen && budget < 3000) begin @(posedge clk); #1; budget++; end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!done_seen) begin failures++; $display("FAIL %s done_timeout got=0 exp=1", name); end
    checks++;
    if (obs.size() !== nb) begin
      failures++; $display("FAIL %s beat_count got=%0d exp=%0d", name, obs.size(), nb);
    end
    for (int k = 0; k < nb && k < obs.size(); k++) begin
      ev = (k < nnz)  ? mw(vb + 32'(k)) : 32'h0;
      ec = (k < nnz)  ? mw(cb + 32'(k)) : 32'h0;
      el = (k < rows) ? mw(lb + 32'(k)) : 32'h0;
      checks++;
      if (obs[k].v !== ev || obs[k].c !== ec || obs[k].l !== el) begin
        failures++;
        $display("FAIL %s beat%0d got=%h/%h/%h exp=%h/%h/%h", name, k,
                 obs[k].v, obs[k].c, obs[k].l, ev, ec, el);
      end
    end
    if (nb > 0 && done_seen) begin
      checks++;
      if (done_cyc - last_beat_cyc !== 1) begin
        failures++; $display("FAIL %s done_latency got=%0d exp=1", name, done_cyc - last_beat_cyc);
      end
    end
    checks++;
    if (acc_total !== 2 * nnz + rows) begin
      failures++; $display("FAIL %s req_count got=%0d exp=%0d", name, acc_total, 2 * nnz + rows);
    end
    checks++;
    if (max_inflight > DEPTH) begin
      failures++; $display("FAIL %s inflight got=%0d exp<=%0d", name, max_inflight, DEPTH);
    end
    checks++;
    if (hold_viol !== 0) begin
      failures++; $display("FAIL %s req_hold got=%0d exp=0", name, hold_viol);
    end
    checks++;
    if (busy !== 1'b0 || spm_fetch_done !== 1'b1 || spm_fetch_stall !== 1'b1) begin
      failures++;
      $display("FAIL %s end_state got=busy%b done%b stall%b exp=busy0 done1 stall1",
               name, busy, spm_fetch_done, spm_fetch_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
    checks++;
    if (spm_fetch_stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%b exp=1", spm_fetch_stall); end
    checks++;
    if (spm_fetch_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", spm_fetch_done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++;
    if ({spm_val, spm_col_idx, spm_row_len} !== 96'h0) begin
      failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", spm_val, spm_col_idx, spm_row_len);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero();
    pulse_start(0, 0, 32'h10, 32'h20, 32'h30);
    checks++;
    if (spm_fetch_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", spm_fetch_done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (acc_total !== 0) begin failures++; $display("FAIL zero_reqs got=%0d exp=0", acc_total); end
    checks++;
    if (spm_fetch_done !== 1'b1) begin failures++; $display("FAIL zero_done_hold got=%b exp=1", spm_fetch_done); end
  endtask

  task automatic test_basic();
    lat = '{2, 2, 2}; lat_jit = 0; ready_mode = 0;
    run_job("basic", 4, 2, 32'h100, 32'h200, 32'h300);
  endtask

  task automatic test_ready_stall();
    lat = '{2, 2, 2}; ready_mode = 1;
    low_from = cyc + 10; low_to = low_from + 10;
    run_job("ready_stall", 24, 9, 32'h1000, 32'h2000, 32'h3000);
    ready_mode = 0;
  endtask

  task automatic test_interleave();
    lat = '{12, 2, 3};
    run_job("interleave", 20, 5, 32'h4000, 32'h4800, 32'h4C00);
    lat = '{2, 2, 2};
  endtask

  task automatic test_init_flush();
    int budget;
    lat = '{25, 25, 25}; acc_limit = 3;
    pulse_start(10, 10, 32'h9000, 32'hA000, 32'hB000);
    budget = 0;
    while (acc_total < 3 && budget < 100) begin @(posedge clk); #1; budget++; end
    checks++;
    if (acc_total !== 3) begin failures++; $display("FAIL init_outstanding got=%0d exp=3", acc_total); end
    repeat (3) @(posedge clk);
    #1 spmv_init = 1'b1;
    @(posedge clk);
    #1 spmv_init = 1'b0;
    checks++;
    if (spm_fetch_stall !== 1'b1 || spm_fetch_done !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL init_clear got=stall%b done%b busy%b valid%b exp=stall1 done0 busy0 valid0",
               spm_fetch_stall, spm_fetch_done, busy, mem_req_valid);
    end
    acc_limit = 1 << 30; lat = '{2, 2, 2};
    run_job("init_new", 6, 6, 32'h5000, 32'h6000, 32'h7000);
  endtask

  task automatic test_async_reset();
    int budget;
    lat = '{2, 2, 2};
    pulse_start(30, 30, 32'hC000, 32'hD000, 32'hE000);
    budget = 0;
    while (obs.size() < 3 && budget < 200) begin @(posedge clk); #1; budget++; end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (spm_fetch_stall !== 1'b1 || spm_fetch_done !== 1'b0) begin
      failures++;
      $display("FAIL arst_flags got=stall%b done%b exp=stall1 done0", spm_fetch_stall, spm_fetch_done);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b0 || {spm_val, spm_col_idx, spm_row_len} !== 96'h0) begin
      failures++;
      $display("FAIL arst_outputs got=valid%b busy%b data%h exp=0", mem_req_valid, busy, spm_val);
    end
    pend.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_job("after_reset", 5, 3, 32'h100, 32'h200, 32'h300);
  endtask

  task automatic test_back_to_back();
    string nm;
    for (int it = 0; it < 5; it++) begin
      for (int s = 0; s < 3; s++) lat[s] = $urandom_range(1, 8);
      lat_jit    = $urandom_range(0, 3);
      ready_mode = (it % 2 == 0) ? 2 : 0;
      inj_tag3   = 1'b1;
      nm = $sformatf("rand%0d", it);
      if (it == 0)
        run_job(nm, 17, 11, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
      else
        run_job(nm, $urandom_range(0, 40), $urandom_range(1, 40), $urandom, $urandom, $urandom);
    end
    inj_tag3 = 1'b0; lat_jit = 0; ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_ready_stall();
    test_interleave();
    test_init_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
